ef_gpio8_apb: RTL and testbench

- 8-bit general-purpose I/O peripheral with an APB slave interface.
- Provides per-pin output data, per-pin direction control and input readback.
- Raises a single interrupt request from per-pin level and edge events.
- Sits on the peripheral APB bus; io_* pins connect to the pad ring.

---
 rtl/ef_gpio8_apb.sv | 131 +++++++++++++
 tb/tb_ef_gpio8_apb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_gpio8_apb.sv
// ef_gpio8_apb: 8-bit GPIO peripheral with an APB slave port.
//
// Provides per-pin output data (DATAO -> io_out), per-pin direction
// (DIR -> io_oe), input readback (DATAI) and one interrupt request built
// from sticky per-pin level/edge flags (RIS), a mask (IM) and a
// write-1-to-clear register (IC).
//
// Ports:
//   PCLK, PRESETn      clock and asynchronous active-low reset
//   PADDR[15:0]        byte address, PADDR[15:2] decoded
//   PSEL, PENABLE,
//   PWRITE, PWDATA     APB request
//   PRDATA, PREADY     APB response (PREADY tied to 1)
//   IRQ                OR of the masked interrupt status
//   io_in/io_out/io_oe pad interface
//
// Optional feature: define GPIO8_IN_SYNC_EN to pass io_in through a
// 2-flop synchronizer before DATAI and the interrupt logic.

module ef_gpio8_apb (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [15:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic [7:0]  io_oe
);

    // Word addresses (byte offset >> 2).
    localparam logic [13:0] ADDR_DATAI = 14'h0000;
    localparam logic [13:0] ADDR_DATAO = 14'h0001;
    localparam logic [13:0] ADDR_DIR   = 14'h0002;
    localparam logic [13:0] ADDR_IM    = 14'h03C0;
    localparam logic [13:0] ADDR_MIS   = 14'h03C1;
    localparam logic [13:0] ADDR_RIS   = 14'h03C2;
    localparam logic [13:0] ADDR_IC    = 14'h03C3;

    logic [13:0] word_addr;
    logic        wr_en;
    logic [7:0]  in_s;
    logic [7:0]  prev_reg;
    logic [7:0]  datao_reg;
    logic [7:0]  dir_reg;
    logic [31:0] im_reg;
    logic [31:0] ris_reg;
    logic [31:0] ris_next;
    logic [31:0] ris_set;
    logic [31:0] ic_clear;
    logic [31:0] mis;
    logic        unused_addr_bits;

    assign word_addr        = PADDR[15:2];
    assign unused_addr_bits = ^PADDR[1:0];
    assign wr_en            = PSEL & PENABLE & PWRITE;

`ifdef GPIO8_IN_SYNC_EN
    logic [7:0] sync1_reg;
    logic [7:0] sync2_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync1_reg <= 8'h00;
            sync2_reg <= 8'h00;
        end else begin
            sync1_reg <= io_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign in_s = sync2_reg;
`else
    assign in_s = io_in;
`endif

    // Flag groups: [7:0] high level, [15:8] low level,
    // [23:16] rising edge, [31:24] falling edge.
    assign ris_set  = {prev_reg & ~in_s, ~prev_reg & in_s, ~in_s, in_s};
    assign ic_clear = (wr_en && (word_addr == ADDR_IC)) ? PWDATA : 32'h0;
    // Set is applied after clear so a persisting condition wins over IC.
    assign ris_next = (ris_reg & ~ic_clear) | ris_set;
    assign mis      = ris_reg & im_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            datao_reg <= 8'h00;
            dir_reg   <= 8'h00;
            im_reg    <= 32'h0;
            ris_reg   <= 32'h0;
            prev_reg  <= 8'h00;
        end else begin
            ris_reg  <= ris_next;
            prev_reg <= in_s;
            if (wr_en) begin
                case (word_addr)
                    ADDR_DATAO: datao_reg <= PWDATA[7:0];
                    ADDR_DIR:   dir_reg   <= PWDATA[7:0];
                    ADDR_IM:    im_reg    <= PWDATA;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = 32'h0;
        if (PSEL) begin
            case (word_addr)
                ADDR_DATAI: PRDATA = {24'h0, in_s};
                ADDR_DATAO: PRDATA = {24'h0, datao_reg};
                ADDR_DIR:   PRDATA = {24'h0, dir_reg};
                ADDR_IM:    PRDATA = im_reg;
                ADDR_MIS:   PRDATA = mis;
                ADDR_RIS:   PRDATA = ris_reg;
                default:    PRDATA = 32'h0;
            endcase
        end
    end

    assign PREADY = 1'b1;
    assign IRQ    = |mis;
    assign io_out = datao_reg;
    assign io_oe  = dir_reg;

endmodule

// File: tb/tb_ef_gpio8_apb.sv
// tb_ef_gpio8_apb: scoreboard bench for ef_gpio8_apb.
// Stimulus issues APB accesses and pin changes, and for every read pushes
// the expected response computed from a behavioural model; a monitor pops
// and compares whenever a read access phase is on the bus.

module tb_ef_gpio8_apb;

    logic        clk;
    logic        rst_n;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        irq;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic [7:0]  io_oe;

    int n_checks = 0;
    int n_errors = 0;

    ef_gpio8_apb dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PADDR   (paddr),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .IRQ     (irq),
        .io_in   (io_in),
        .io_out  (io_out),
        .io_oe   (io_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: registers as plain variables, flags per pin.
    // ------------------------------------------------------------------
    logic [7:0]  m_datao, m_dir, m_prev, m_sync1, m_sync2;
    logic [31:0] m_im, m_ris;

    function automatic logic [7:0] model_s();
`ifdef GPIO8_IN_SYNC_EN
        return m_sync2;
`else
        return io_in;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0]  s;
        logic [31:0] set_v, clr_v, new_ris;
        if (!rst_n) begin
            m_datao <= 8'h00;
            m_dir   <= 8'h00;
            m_im    <= 32'h0;
            m_ris   <= 32'h0;
            m_prev  <= 8'h00;
            m_sync1 <= 8'h00;
            m_sync2 <= 8'h00;
        end else begin
            s     = model_s();
            set_v = 32'h0;
            clr_v = 32'h0;
            for (int i = 0; i < 8; i++) begin
                if (s[i]) set_v[i] = 1'b1;
                else      set_v[8 + i] = 1'b1;
                if (!m_prev[i] && s[i]) set_v[16 + i] = 1'b1;
                if (m_prev[i] && !s[i]) set_v[24 + i] = 1'b1;
            end
            if (psel && penable && pwrite) begin
                case (paddr & 16'hFFFC)
                    16'h0004: m_datao <= pwdata[7:0];
                    16'h0008: m_dir   <= pwdata[7:0];
                    16'h0F00: m_im    <= pwdata;
                    16'h0F0C: clr_v = pwdata;
                    default:  ;
                endcase
            end
            for (int b = 0; b < 32; b++)
                new_ris[b] = set_v[b] ? 1'b1 : (clr_v[b] ? 1'b0 : m_ris[b]);
            m_ris   <= new_ris;
            m_prev  <= s;
            m_sync1 <= io_in;
            m_sync2 <= m_sync1;
        end
    end

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {24'h0, model_s()};
            16'h0004: return {24'h0, m_datao};
            16'h0008: return {24'h0, m_dir};
            16'h0F00: return m_im;
            16'h0F04: return m_ris & m_im;
            16'h0F08: return m_ris;
            default:  return 32'h0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  out;
        logic [7:0]  oe;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && psel && penable && !pwrite) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("rd addr=%h data=%h out=%h oe=%h irq=%b", e.addr, prdata, io_out, io_oe, irq);
                check("prdata", prdata, e.data);
                check("io_out", {24'h0, io_out}, {24'h0, e.out});
                check("io_oe", {24'h0, io_oe}, {24'h0, e.oe});
                check("irq", {31'h0, irq}, {31'h0, e.irq});
                check("pready", {31'h0, pready}, 32'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks: all called and returning at posedge + 1.
    // ------------------------------------------------------------------
    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        $display("wr addr=%h data=%h", a, d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a);
        exp_t e;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1 penable = 1'b1;
        e.addr = a;
        e.data = model_read(a);
        e.out  = m_datao;
        e.oe   = m_dir;
        e.irq  = |(m_ris & m_im);
        exp_q.push_back(e);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] A_DATAI = 16'h0000, A_DATAO = 16'h0004, A_DIR = 16'h0008;
    localparam logic [15:0] A_IM = 16'h0F00, A_MIS = 16'h0F04, A_RIS = 16'h0F08, A_IC = 16'h0F0C;

    initial begin
        logic [15:0] addr_tab [8];
        logic [15:0] a;
        int          wait_cycles;
        addr_tab = '{A_DATAI, A_DATAO, A_DIR, A_IM, A_MIS, A_RIS, A_IC, 16'h0010};

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'h0; pwdata = 32'h0; io_in = 8'h00;

        // Reset state, sampled while reset is held.
        #12 psel = 1'b1;
        paddr = A_RIS;   #2 check("rst_ris",   prdata, 32'h0);
        paddr = A_DATAO; #2 check("rst_datao", prdata, 32'h0);
        paddr = A_DIR;   #2 check("rst_dir",   prdata, 32'h0);
        paddr = A_IM;    #2 check("rst_im",    prdata, 32'h0);
        check("rst_io_out", {24'h0, io_out}, 32'h0);
        check("rst_io_oe",  {24'h0, io_oe},  32'h0);
        check("rst_irq",    {31'h0, irq},    32'h0);
        psel = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        apb_read(A_DATAO);
        apb_read(A_DIR);
        apb_read(A_IM);

        // Output path.
        apb_write(A_DIR, 32'hFF);
        apb_write(A_DATAO, 32'hA5);
        check("out_io_out", {24'h0, io_out}, 32'hA5);
        check("out_io_oe",  {24'h0, io_oe},  32'hFF);
        apb_read(A_DATAO);

        // Input path.
        apb_write(A_DIR, 32'h00);
        io_in = 8'hAB;
        idle(3);
        apb_read(A_DATAI);

        // Edge interrupt.
        io_in = 8'h00;
        apb_write(A_IM, 32'h0001_0000);
        idle(3);
        apb_write(A_IC, 32'hFFFF_FFFF);
        io_in = 8'h01;
        idle(3);
        apb_read(A_RIS);
        apb_read(A_MIS);
        apb_write(A_IC, 32'h0001_0000);
        apb_read(A_RIS);
        apb_read(A_MIS);

        // Level interrupt, set beats clear.
        apb_write(A_IM, 32'h0000_0100);
        io_in = 8'h00;
        idle(3);
        apb_write(A_IC, 32'h0000_0100);
        apb_read(A_RIS);
        io_in = 8'h01;
        idle(3);
        apb_write(A_IC, 32'h0000_0100);
        apb_read(A_RIS);
        apb_read(A_MIS);

        // Decode.
        apb_read(16'h0010);
        apb_read(A_IC);
        apb_write(A_DATAI, 32'hFF);
        apb_read(A_DATAI);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            a = addr_tab[$urandom_range(0, 7)] | 16'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0, 1, 2: apb_write(a, $urandom);
                3, 4, 5: apb_read(a);
                6:       io_in = 8'($urandom);
                default: idle($urandom_range(1, 3));
            endcase
        end

        // Reset asserted in the middle of a write access.
        apb_write(A_DATAO, 32'h3C);
        apb_write(A_DIR, 32'hC3);
        psel = 1'b1; pwrite = 1'b1; paddr = A_DATAO; pwdata = 32'h5A;
        @(posedge clk); #1 penable = 1'b1;
        #3 rst_n = 1'b0;
        #1 check("abort_io_out", {24'h0, io_out}, 32'h0);
        check("abort_io_oe", {24'h0, io_oe}, 32'h0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        apb_read(A_DATAO);
        apb_read(A_DIR);
        apb_read(A_IM);

        // Drain: every pushed expectation must have been consumed.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            idle(1);
            wait_cycles++;
        end
        check("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
